// File: rtl/depth_level_quant.sv
// depth_level_quant: holds per-frame threshold sets, quantises depth pixels into levels, keeps per-frame level counts
module depth_level_quant #(
   parameter int P_DEPTH_BIT = 8,
   parameter int P_TH_NUM    = 4,
   parameter int P_LEVEL_BIT = 3,
   parameter int P_CNT_BIT   = 16
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               th_valid,
   output logic                               th_ready,
   input  logic [P_TH_NUM*P_DEPTH_BIT-1:0]    th,
   input  logic                               pix_valid,
   output logic                               pix_ready,
   input  logic [P_DEPTH_BIT-1:0]             pix_depth,
   input  logic                               pix_sof,
   input  logic                               pix_eof,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [P_LEVEL_BIT-1:0]             out_level,
   output logic                               out_sof,
   output logic                               out_eof,
   output logic                               cnt_valid,
   output logic [(P_TH_NUM+1)*P_CNT_BIT-1:0]  level_cnt,
   output logic                               th_stale,
   output logic                               frm_err
);
   localparam int TW = P_TH_NUM*P_DEPTH_BIT;
   localparam int CW = (P_TH_NUM+1)*P_CNT_BIT;
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] pend_q, act_q, th_use;
   logic pend_full_q, pend_full_d;
   logic out_valid_q, out_sof_q, out_eof_q, cnt_valid_q, th_stale_q, frm_err_q;
   logic [P_LEVEL_BIT-1:0] out_level_q, lvl;
   logic [CW-1:0] cnt_q, cnt_d, base, level_cnt_q;
   logic acc, sof_acc, proc;
   assign th_ready  = !pend_full_q;
   assign pix_ready = !out_valid_q || out_ready;
   assign acc       = pix_valid && pix_ready;
   assign sof_acc   = acc && pix_sof;
   assign proc      = acc && (pix_sof || state_q == ACTIVE);
   assign th_use    = (sof_acc && pend_full_q) ? pend_q : act_q;
   assign pend_full_d = pend_full_q ? !sof_acc : th_valid;
   assign state_d   = proc ? (pix_eof ? IDLE : ACTIVE) : state_q;
   assign out_valid = out_valid_q;
   assign out_level = out_level_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign cnt_valid = cnt_valid_q;
   assign level_cnt = level_cnt_q;
   assign th_stale  = th_stale_q;
   assign frm_err   = frm_err_q;
   // level is the number of thresholds at or below the pixel depth; sof uses the freshly promoted set
   always_comb begin
      lvl = '0;
      for (int i = 0; i < P_TH_NUM; i++)
         lvl = lvl + P_LEVEL_BIT'(pix_depth >= th_use[i*P_DEPTH_BIT +: P_DEPTH_BIT]);
   end
   // per-level counts restart on sof and saturate instead of wrapping
   always_comb begin
      base  = pix_sof ? '0 : cnt_q;
      cnt_d = base;
      for (int j = 0; j <= P_TH_NUM; j++)
         if (int'(lvl) == j && !(&base[j*P_CNT_BIT +: P_CNT_BIT]))
            cnt_d[j*P_CNT_BIT +: P_CNT_BIT] = base[j*P_CNT_BIT +: P_CNT_BIT] + 1'b1;
   end
   // threshold slots, frame state, output stage, counters and status pulses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         act_q       <= '1;
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_level_q <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         cnt_q       <= '0;
         level_cnt_q <= '0;
         cnt_valid_q <= 1'b0;
         th_stale_q  <= 1'b0;
         frm_err_q   <= 1'b0;
      end else begin
         if (th_valid && th_ready) pend_q <= th;
         pend_full_q <= pend_full_d;
         act_q       <= th_use;
         state_q     <= state_d;
         if (pix_ready) out_valid_q <= proc;
         if (proc) begin
            out_level_q <= lvl;
            out_sof_q   <= pix_sof;
            out_eof_q   <= pix_eof;
            cnt_q       <= cnt_d;
         end
         if (proc && pix_eof) level_cnt_q <= cnt_d;
         cnt_valid_q <= proc && pix_eof;
         th_stale_q  <= sof_acc && !pend_full_q;
         frm_err_q   <= acc && (state_q == ACTIVE ? pix_sof : !pix_sof);
      end
   end
endmodule
